// File: rtl/waveform_stream_converter.sv
// waveform_stream_converter: reads DEPTH LUT samples, converts them per a one-hot
// mode and streams them out on valid/ready. Optional macro: WFC_AMPLITUDE_EN (amp scaling).
module waveform_stream_converter #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int FM_MIN_STEP = 1,
    parameter int FM_MAX_STEP = 20,
    localparam int A          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        mode,
`ifdef WFC_AMPLITUDE_EN
    input  logic [DATA_W-1:0] amp,
`endif
    output logic              lut_rd_en,
    output logic [A-1:0]      lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [A-1:0]      out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              mode_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [DATA_W-1:0] MAXV = '1;
    localparam logic [A-1:0]      LAST = A'(DEPTH - 1);
    localparam int PW   = DATA_W + 32;
    localparam int TW   = DATA_W + 1;
    localparam int TSH  = DATA_W + 1 - A;
    localparam int SSH  = DATA_W - A;
    localparam int DIFF = FM_MAX_STEP - FM_MIN_STEP;

    state_e            state_q;
    logic [4:0]        mode_q;
    logic              mode_ok_q;
    logic              mode_err_q;
    logic              busy_q;
    logic [A-1:0]      rd_ptr_q;
    logic              infl_q;
    logic [A-1:0]      ret_idx_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] d0_q, d1_q;
    logic [A-1:0]      i0_q, i1_q;
    logic [31:0]       fm_pos_q;
    logic              fm_bit_q;

    logic              pop;
    logic              accept;
    logic              last_hs;
    logic              rd_en;
    logic [2:0]        occ;
    logic [PW-1:0]     fm_prod;
    logic [PW-1:0]     fm_quot;
    logic [31:0]       fm_step;
    logic [31:0]       fm_pos_inc;
    logic              fm_tog;
    logic [31:0]       fm_pos_d;
    logic              fm_bit_d;
    logic [A-1:0]      trg_half;
    logic [TW-1:0]     trg_w;
    logic [DATA_W-1:0] trg_v;
    logic [DATA_W-1:0] saw_v;
    logic [DATA_W-1:0] conv;
    logic [DATA_W-1:0] wr_data;

`ifdef WFC_AMPLITUDE_EN
    logic [DATA_W-1:0]   amp_q;
    logic [2*DATA_W:0]   amp_prod;
`endif

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = d0_q;
    assign out_idx   = i0_q;
    assign out_last  = out_valid && (i0_q == LAST);
    assign pop       = out_valid && out_ready;
    assign accept    = (state_q == IDLE) && start && !abort;
    assign last_hs   = pop && out_last && (state_q == DRAIN) && !abort;
    assign done      = last_hs;
    assign busy      = busy_q;
    assign mode_err  = mode_err_q;
    assign lut_addr  = rd_ptr_q;
    assign lut_rd_en = rd_en;

    // Read issue: keep FIFO entries plus the outstanding read within two.
    always_comb begin
        occ   = 3'(cnt_q) - 3'(pop) + 3'(infl_q);
        rd_en = (state_q == RUN) && (occ < 3'd2);
    end

    // FM half-period from the returned sample and the next pos/bit values.
    always_comb begin
        fm_prod    = PW'(lut_data) * PW'(DIFF);
        fm_quot    = fm_prod / PW'(MAXV);
        fm_step    = 32'(FM_MAX_STEP) - 32'(fm_quot);
        fm_pos_inc = fm_pos_q + 32'd1;
        fm_tog     = (fm_pos_inc >= fm_step);
        fm_pos_d   = fm_tog ? 32'd0 : fm_pos_inc;
        fm_bit_d   = fm_bit_q ^ fm_tog;
    end

    // Sample conversion for the data returning from the LUT this cycle.
    always_comb begin
        trg_half = ret_idx_q[A-1] ? ~ret_idx_q : ret_idx_q;
        trg_w    = TW'(trg_half) << TSH;
        trg_v    = DATA_W'(trg_w);
        saw_v    = DATA_W'(ret_idx_q) << SSH;
        conv     = '0;
        if (mode_ok_q) begin
            unique case (1'b1)
                mode_q[0]: conv = lut_data;
                mode_q[1]: conv = trg_v;
                mode_q[2]: conv = lut_data[DATA_W-1] ? MAXV : '0;
                mode_q[3]: conv = fm_bit_d ? MAXV : '0;
                mode_q[4]: conv = saw_v;
                default:   conv = '0;
            endcase
        end
    end

`ifdef WFC_AMPLITUDE_EN
    // Amplitude scaling; amp = MAX reduces to identity.
    always_comb begin
        amp_prod = (2*DATA_W+1)'(conv) * ((2*DATA_W+1)'(amp_q) + 1'b1);
        wr_data  = DATA_W'(amp_prod >> DATA_W);
    end
`else
    // Samples pass through unscaled.
    always_comb begin
        wr_data = conv;
    end
`endif

    // Frame control FSM: start latch, read pointer, in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            mode_ok_q  <= 1'b0;
            mode_err_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_ptr_q   <= '0;
            infl_q     <= 1'b0;
            ret_idx_q  <= '0;
        end else if (abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rd_ptr_q <= '0;
            infl_q   <= 1'b0;
        end else begin
            infl_q <= rd_en;
            if (rd_en) begin
                ret_idx_q <= rd_ptr_q;
                rd_ptr_q  <= rd_ptr_q + A'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        mode_q     <= mode;
                        mode_ok_q  <= $onehot(mode);
                        mode_err_q <= !$onehot(mode);
                        busy_q     <= 1'b1;
                        rd_ptr_q   <= '0;
                    end
                end
                RUN: begin
                    if (rd_en && (rd_ptr_q == LAST)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WFC_AMPLITUDE_EN
    // Amplitude is latched with the mode on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amp_q <= '0;
        end else if (accept) begin
            amp_q <= amp;
        end
    end
`endif

    // FM oscillator state, stepped once per sample written to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_pos_q <= '0;
            fm_bit_q <= 1'b0;
        end else if (abort || accept) begin
            fm_pos_q <= '0;
            fm_bit_q <= 1'b0;
        end else if (infl_q && mode_ok_q && mode_q[3]) begin
            fm_pos_q <= fm_pos_d;
            fm_bit_q <= fm_bit_d;
        end
    end

    // Two-entry output FIFO; entry 0 is the head presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            d0_q  <= '0;
            d1_q  <= '0;
            i0_q  <= '0;
            i1_q  <= '0;
        end else if (abort) begin
            cnt_q <= 2'd0;
        end else begin
            unique case ({infl_q, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        d0_q <= wr_data;
                        i0_q <= ret_idx_q;
                    end else begin
                        d1_q <= wr_data;
                        i1_q <= ret_idx_q;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    d0_q  <= d1_q;
                    i0_q  <= i1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        d0_q <= wr_data;
                        i0_q <= ret_idx_q;
                    end else begin
                        d0_q <= d1_q;
                        i0_q <= i1_q;
                        d1_q <= wr_data;
                        i1_q <= ret_idx_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
